// File: rtl/set_rate_ctrl_if.sv
// set_rate_ctrl_if: set-button inputs, clock-generator strobes and increment/mode outputs of set_rate_ctrl
interface set_rate_ctrl_if;
    logic       i_set_btn;
    logic       i_slow_set_stb;
    logic       i_fast_set_stb;
    logic       o_inc_stb;
    logic [1:0] o_mode;
    modport master (output i_set_btn, i_slow_set_stb, i_fast_set_stb, input o_inc_stb, o_mode);
    modport slave (input i_set_btn, i_slow_set_stb, i_fast_set_stb, output o_inc_stb, o_mode);
endinterface

// File: rtl/set_rate_ctrl.sv
// set_rate_ctrl: set-button auto-repeat (press, hold delay, slow then fast increments); FAST state built only with SET_RATE_FAST_EN
module set_rate_ctrl #(
    parameter int HOLD_DELAY = 2,
    parameter int SLOW_COUNT = 4
) (
    input logic          i_clk,
    input logic          i_reset_n,
    set_rate_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SLOW = 2'd2, FAST = 2'd3} state_t;
    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx, cnt_inc;
    logic       btn_q, inc_q, inc_nx, press;
    assign press   = bus.i_set_btn & ~btn_q;
    assign cnt_inc = (cnt == 4'hf) ? cnt : cnt + 4'd1;
`ifndef SET_RATE_FAST_EN
    logic unused_fast;
    assign unused_fast = bus.i_fast_set_stb;
`endif
    // btn_q resets high so a button held through reset release is not a press
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            btn_q <= 1'b1;
            inc_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            btn_q <= bus.i_set_btn;
            inc_q <= inc_nx;
        end
    end
    // release beats any coincident strobe; !inc_q keeps pulses from abutting
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        inc_nx   = 1'b0;
        case (state)
            IDLE: if (press) begin
                state_nx = WAIT;
                cnt_nx   = '0;
                inc_nx   = 1'b1;
            end
            WAIT: if (!bus.i_set_btn) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (bus.i_slow_set_stb) begin
                state_nx = (cnt_inc == 4'(HOLD_DELAY)) ? SLOW : WAIT;
                cnt_nx   = (cnt_inc == 4'(HOLD_DELAY)) ? 4'd0 : cnt_inc;
            end
            SLOW: if (!bus.i_set_btn) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (bus.i_slow_set_stb && !inc_q) begin
                inc_nx = 1'b1;
                cnt_nx = cnt_inc;
`ifdef SET_RATE_FAST_EN
                state_nx = (cnt_inc == 4'(SLOW_COUNT)) ? FAST : SLOW;
`endif
            end
`ifdef SET_RATE_FAST_EN
            FAST: if (!bus.i_set_btn) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (bus.i_fast_set_stb && !inc_q) begin
                inc_nx = 1'b1;
            end
`endif
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end
    assign bus.o_inc_stb = inc_q;
    assign bus.o_mode    = state;
endmodule

// File: doc/set_rate_ctrl.md
SET_RATE_CTRL -- requirements
Module: set_rate_ctrl

Interface
REQ-001 SHALL have parameter HOLD_DELAY, default 2: number of i_slow_set_stb pulses after press before auto-repeat starts (legal 1..15).
REQ-002 SHALL have parameter SLOW_COUNT, default 4: number of slow-rate increments before fast rate (legal 1..15).
REQ-003 SHALL have port i_clk, input, 1, system clock.
REQ-004 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_set_btn, input, 1, debounced set-button level, synchronous to i_clk, 1 = pressed.
REQ-006 SHALL have port i_slow_set_stb, input, 1, 1-cycle 2 Hz strobe from the clock generator.
REQ-007 SHALL have port i_fast_set_stb, input, 1, 1-cycle 8 Hz strobe from the clock generator.
REQ-008 SHALL have port o_inc_stb, output, 1, registered 1-cycle increment strobe to the time counter.
REQ-009 SHALL have port o_mode, output, 2, current state encoding: 0 IDLE, 1 WAIT, 2 SLOW, 3 FAST.

Function
REQ-010 SHALL implement a registered FSM with states IDLE, WAIT, SLOW, FAST; o_mode reflects the state register directly.
REQ-011 SHALL detect a press as i_set_btn=1 while a registered copy of the previous i_set_btn is 0.
REQ-012 IDLE: on press, SHALL assert o_inc_stb on the following cycle (latency 1), clear the delay counter, go to WAIT.
REQ-013 WAIT: SHALL count i_slow_set_stb pulses in a 4-bit counter, producing no o_inc_stb; on the pulse that brings the count to HOLD_DELAY, go to SLOW with the counter cleared, no increment on that pulse.
REQ-014 SLOW: each i_slow_set_stb SHALL produce one o_inc_stb the next cycle and increment the counter; on the increment that brings the count to SLOW_COUNT, go to FAST.
REQ-015 FAST: each i_fast_set_stb SHALL produce one o_inc_stb the next cycle; i_slow_set_stb SHALL be ignored; a coincident slow and fast strobe SHALL produce exactly one pulse.
REQ-016 In WAIT, SLOW and FAST, i_set_btn=0 SHALL return the FSM to IDLE on the next edge and clear the counter.
REQ-017 Release SHALL take priority over a coincident strobe: no o_inc_stb is generated for that cycle.
REQ-018 In IDLE, strobes SHALL be ignored; a button held across reset deassertion SHALL NOT count as a press.
REQ-019 o_inc_stb SHALL never be high two consecutive cycles and SHALL be 0 whenever no qualifying event occurred in the prior cycle.
REQ-020 Counter SHALL saturate at 15 and never wrap.

Reset
REQ-021 i_reset_n=0 SHALL immediately, without a clock, force state IDLE, counter 0, o_inc_stb 0, o_mode 0.
REQ-022 The previous-button register SHALL reset to 1, so that a button already pressed at release of reset is not a press (REQ-018).
REQ-023 Reset asserted mid-operation (any state) SHALL abort the sequence; after release, a new press is required to restart.

Configuration
REQ-024 Macro SET_RATE_FAST_EN defined: FAST state and i_fast_set_stb behave per REQ-014/REQ-015.
REQ-025 Macro SET_RATE_FAST_EN undefined: FAST state is not built, SLOW persists until release, i_fast_set_stb is unused, o_mode never equals 3.

Verification
REQ-026 Reset, press held with defaults -> one o_inc_stb 1 cycle after press, o_mode 1, no pulses on the first 2 slow strobes, then o_mode 2.
REQ-027 Continue holding -> 4 pulses, each 1 cycle after a slow strobe, then o_mode 3 and one pulse per fast strobe (8 per second).
REQ-028 Release coincident with a slow strobe in SLOW -> no pulse, o_mode 0 next cycle.
REQ-029 Slow and fast strobes coincident in FAST -> exactly one 1-cycle o_inc_stb.
REQ-030 Button held high through reset release -> o_mode stays 0, no pulses; release then press -> normal sequence.
REQ-031 Build without SET_RATE_FAST_EN, hold 10 s -> o_mode stays 2, pulses only at slow-strobe rate.
